// File: rtl/stage_fetch1.sv
// Second fetch stage: pairs synchronous imem read data with the PC metadata captured at
// request time, buffers one instruction across decode stalls, squashes on redirect, predecodes.
module stage_fetch1 #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pcF0,
    input  logic [XLEN-1:0] pcPlus4F0,
    input  logic            bPredictedTakenF0,
    input  logic            imemRen,
    input  logic [XLEN-1:0] imemRdata,
    input  logic            stallD,
    input  logic            flush,
    output logic            stallF,
    output logic            validD,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcPlus4D,
    output logic            bPredictedTakenD,
    output logic            isBranchD,
    output logic            isJalD,
    output logic            isJalrD,
    output logic [1:0]      fsm_state
);

    // Handshake: a request is accepted at any edge with imemRen=1 and flush=0; decode
    // accepts the D registers at any edge with stallD=0. stallF blocks new requests.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;

    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pend_pc4;
    logic            pend_bp;

    logic            hold_valid;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_pc4;
    logic            hold_bp;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = imemRen ? PEND : IDLE;
                PEND: begin
                    if (stallD) state_nxt = HOLD;
                    else        state_nxt = imemRen ? PEND : IDLE;
                end
                HOLD: begin
                    if (!stallD) state_nxt = imemRen ? PEND : IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Wrong-path requests issued alongside a redirect are never captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_pc  <= '0;
            pend_pc4 <= '0;
            pend_bp  <= 1'b0;
        end else if (imemRen && !flush) begin
            pend_pc  <= pcF0;
            pend_pc4 <= pcPlus4F0;
            pend_bp  <= bPredictedTakenF0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
            hold_pc4   <= '0;
            hold_bp    <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (state == PEND && stallD) begin
            hold_valid <= 1'b1;
            hold_instr <= imemRdata;
            hold_pc    <= pend_pc;
            hold_pc4   <= pend_pc4;
            hold_bp    <= pend_bp;
        end else if (state == HOLD && !stallD) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validD           <= 1'b0;
            instrD           <= NOP_INSTR;
            pcD              <= '0;
            pcPlus4D         <= '0;
            bPredictedTakenD <= 1'b0;
        end else if (flush) begin
            validD           <= 1'b0;
            instrD           <= NOP_INSTR;
            bPredictedTakenD <= 1'b0;
        end else if (!stallD) begin
            case (state)
                PEND: begin
                    validD           <= 1'b1;
                    instrD           <= imemRdata;
                    pcD              <= pend_pc;
                    pcPlus4D         <= pend_pc4;
                    bPredictedTakenD <= pend_bp;
                end
                HOLD: begin
                    validD           <= hold_valid;
                    instrD           <= hold_valid ? hold_instr : NOP_INSTR;
                    pcD              <= hold_pc;
                    pcPlus4D         <= hold_pc4;
                    bPredictedTakenD <= hold_valid & hold_bp;
                end
                default: begin
                    validD           <= 1'b0;
                    instrD           <= NOP_INSTR;
                    bPredictedTakenD <= 1'b0;
                end
            endcase
        end
    end

    assign stallF    = stallD | (state == HOLD);
    assign isBranchD = validD && (instrD[6:0] == 7'b1100011);
    assign isJalD    = validD && (instrD[6:0] == 7'b1101111);
    assign isJalrD   = validD && (instrD[6:0] == 7'b1100111);
    assign fsm_state = state;

endmodule

// File: tb/tb_stage_fetch1.sv
// Directed table-driven bench for stage_fetch1 plus a hand-written async-reset sequence.
module tb_stage_fetch1;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] GARB = 32'hdeadbeef;

    logic        clk;
    logic        rst;
    logic [31:0] pcF0;
    logic [31:0] pcPlus4F0;
    logic        bPredictedTakenF0;
    logic        imemRen;
    logic [31:0] imemRdata;
    logic        stallD;
    logic        flush;
    logic        stallF;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcPlus4D;
    logic        bPredictedTakenD;
    logic        isBranchD;
    logic        isJalD;
    logic        isJalrD;
    logic [1:0]  fsm_state;

    stage_fetch1 dut (
        .clk(clk), .rst(rst), .pcF0(pcF0), .pcPlus4F0(pcPlus4F0),
        .bPredictedTakenF0(bPredictedTakenF0), .imemRen(imemRen), .imemRdata(imemRdata),
        .stallD(stallD), .flush(flush), .stallF(stallF), .validD(validD), .instrD(instrD),
        .pcD(pcD), .pcPlus4D(pcPlus4D), .bPredictedTakenD(bPredictedTakenD),
        .isBranchD(isBranchD), .isJalD(isJalD), .isJalrD(isJalrD), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs driven during the cycle, outputs expected at mid-cycle.
    typedef struct {
        logic        ren;
        logic [31:0] pc;
        logic        bp;
        logic [31:0] rdata;
        logic        stall;
        logic        fl;
        logic        ev;
        logic [31:0] ei;
        logic        cpc;
        logic [31:0] epc;
        logic        ebp;
        logic        esf;
        logic [2:0]  ecls;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic ren, input logic [31:0] pc, input logic bp,
                       input logic [31:0] rdata, input logic stall, input logic fl,
                       input logic ev, input logic [31:0] ei, input logic cpc,
                       input logic [31:0] epc, input logic ebp, input logic esf,
                       input logic [2:0] ecls);
        vec_t v;
        v = '{ren, pc, bp, rdata, stall, fl, ev, ei, cpc, epc, ebp, esf, ecls};
        vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ren, input logic [31:0] pc, input logic bp,
                         input logic [31:0] rdata, input logic stall, input logic fl);
        imemRen           = ren;
        pcF0              = pc;
        pcPlus4F0         = pc + 32'd4;
        bPredictedTakenF0 = bp;
        imemRdata         = rdata;
        stallD            = stall;
        flush             = fl;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, GARB, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 0, {31'b0, validD}, 32'd0);
        check("rst_instr", 0, instrD, NOP);
        check("rst_pc", 0, pcD, 32'h0);
        check("rst_pc4", 0, pcPlus4D, 32'h0);
        check("rst_bp", 0, {31'b0, bPredictedTakenD}, 32'd0);
        check("rst_cls", 0, {29'b0, isBranchD, isJalD, isJalrD}, 32'd0);
        check("rst_stallf", 0, {31'b0, stallF}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // back-to-back fetches
        add(1, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(1, 32'h04, 0, 32'h00500093, 0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(1, 32'h08, 0, 32'h00a00113, 0, 0, 1, 32'h00500093, 1, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, 32'h002081b3, 0, 0, 1, 32'h00a00113, 1, 32'h04, 0, 0, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 1, 32'h002081b3, 1, 32'h08, 0, 0, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        // decode stall across the data-return cycle
        add(1, 32'h10, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, 32'h0000006f, 1, 0, 0, NOP,          0, 32'h00, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         1, 0, 0, NOP,          0, 32'h00, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         1, 0, 0, NOP,          0, 32'h00, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 1, 32'h0000006f, 1, 32'h10, 0, 0, 3'b010);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        // flush in the data-return cycle, wrong-path request alongside it
        add(1, 32'h20, 1, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(1, 32'h24, 0, 32'h00100093, 0, 1, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, 32'h00200093, 0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(1, 32'h30, 1, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, 32'h00300093, 0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 1, 32'h00300093, 1, 32'h30, 1, 0, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        // flush while holding
        add(1, 32'h50, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, 32'h00400093, 1, 0, 0, NOP,          0, 32'h00, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         1, 1, 0, NOP,          0, 32'h00, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         1, 0, 0, NOP,          0, 32'h00, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        // branch / jalr predecode, then bubble
        add(1, 32'h40, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(1, 32'h44, 0, 32'h00208463, 0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, 32'h000080e7, 0, 0, 1, 32'h00208463, 1, 32'h40, 0, 0, 3'b100);
        add(0, 32'h00, 0, GARB,         0, 0, 1, 32'h000080e7, 1, 32'h44, 0, 0, 3'b001);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        // stall with a valid instruction already in D
        add(1, 32'h60, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(1, 32'h64, 0, 32'h00c00193, 0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);
        add(0, 32'h00, 0, 32'h0000006f, 1, 0, 1, 32'h00c00193, 1, 32'h60, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 1, 32'h00c00193, 1, 32'h60, 0, 1, 3'b000);
        add(0, 32'h00, 0, GARB,         0, 0, 1, 32'h0000006f, 1, 32'h64, 0, 0, 3'b010);
        add(0, 32'h00, 0, GARB,         0, 0, 0, NOP,          0, 32'h00, 0, 0, 3'b000);

        foreach (vq[i]) begin
            drive(vq[i].ren, vq[i].pc, vq[i].bp, vq[i].rdata, vq[i].stall, vq[i].fl);
            @(negedge clk);
            check("valid", i, {31'b0, validD}, {31'b0, vq[i].ev});
            check("instr", i, instrD, vq[i].ei);
            check("stallf", i, {31'b0, stallF}, {31'b0, vq[i].esf});
            check("cls", i, {29'b0, isBranchD, isJalD, isJalrD}, {29'b0, vq[i].ecls});
            if (vq[i].cpc) begin
                check("pc", i, pcD, vq[i].epc);
                check("pc4", i, pcPlus4D, vq[i].epc + 32'd4);
                check("bp", i, {31'b0, bPredictedTakenD}, {31'b0, vq[i].ebp});
            end
            @(posedge clk);
            #1;
        end

        // asynchronous reset while a fetch is pending
        drive(1'b1, 32'h70, 1'b0, GARB, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 32'h74, 1'b0, 32'h00700093, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 1'b0, 32'h00800093, 1'b0, 1'b0);
        check("pre_rst_valid", 1, {31'b0, validD}, 32'd1);
        check("pre_rst_pc", 1, pcD, 32'h70);
        check("pre_rst_state", 1, {30'b0, fsm_state}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 1, {31'b0, validD}, 32'd0);
        check("arst_instr", 1, instrD, NOP);
        check("arst_pc", 1, pcD, 32'h0);
        check("arst_pc4", 1, pcPlus4D, 32'h0);
        check("arst_state", 1, {30'b0, fsm_state}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 1, {31'b0, validD}, 32'd0);
        @(posedge clk);
        #1 imemRdata = GARB;
        @(negedge clk);
        check("post_rst_valid", 2, {31'b0, validD}, 32'd0);
        check("post_rst_instr", 2, instrD, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_fetch1.md
Name: stage_fetch1

Overview:
- Second fetch stage, directly downstream of the PC/fetch-0 stage.
- Aligns the synchronous instruction-memory read data (returned one cycle after the request) with the PC metadata captured at request time.
- Buffers that data across decode stalls, squashes wrong-path fetches on an execute-stage redirect, and predecodes control-flow class.
- Drives the registered F/D pipeline boundary.

Parameters:
- NOP_INSTR, 32'h00000013, instruction driven on instrD when no valid instruction is present (addi x0,x0,0).
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low (0 = reset).
- pcF0  in  XLEN  PC of the request issued this cycle.
- pcPlus4F0  in  XLEN  pcF0+4.
- bPredictedTakenF0  in  1  predictor-taken flag for pcF0.
- imemRen  in  1  a fetch request for pcF0 is issued this cycle.
- imemRdata  in  XLEN  read data; valid the cycle after a cycle with imemRen=1.
- stallD  in  1  decode cannot accept a new instruction this cycle.
- flush  in  1  execute-stage redirect (wrong branch / taken jump); squashes all in-flight fetches.
- stallF  out  1  stall request to fetch-0 (combinational).
- validD  out  1  instrD/pcD are a real instruction.
- instrD  out  XLEN  instruction to decode.
- pcD  out  XLEN  PC of instrD.
- pcPlus4D  out  XLEN  pcD+4.
- bPredictedTakenD  out  1  prediction flag for instrD.
- isBranchD  out  1  instrD[6:0]==7'b1100011, gated by validD.
- isJalD  out  1  instrD[6:0]==7'b1101111, gated by validD.
- isJalrD  out  1  instrD[6:0]==7'b1100111, gated by validD.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pending and hold registers cleared.
  - validD=0, instrD=NOP_INSTR, pcD=0, pcPlus4D=0, bPredictedTakenD=0, predecode flags=0.
  - Deassertion is sampled synchronously. A reset mid-operation drops all in-flight requests; read data returning after reset is ignored.
- Request capture:
  - Condition: imemRen=1 and flush=0 at a rising edge.
  - Stores {pcF0, pcPlus4F0, bPredictedTakenF0} into the pending registers and sets the request-in-flight flag.
  - A request issued in the flush cycle is wrong-path and is never captured.
- States:
  - IDLE: nothing in flight.
  - PEND: data returns this cycle on imemRdata.
  - HOLD: returned data is held in the hold buffer, waiting for decode.
- Transitions (flush has priority over everything):
  - Any state, flush=1 -> IDLE. At the edge: validD=0, instrD=NOP_INSTR, hold buffer invalidated, pending dropped.
  - IDLE: imemRen -> PEND, else stay IDLE. D registers load validD=0 / NOP_INSTR unless stallD=1, in which case they hold.
  - PEND, stallD=0: D registers load {imemRdata, pending metadata} with validD=1. Next state is PEND if imemRen, else IDLE.
  - PEND, stallD=1: imemRdata and metadata are copied into the hold buffer; D registers hold -> HOLD.
  - HOLD, stallD=0: D registers load from the hold buffer with validD=1. Next state is PEND if imemRen, else IDLE.
  - HOLD, stallD=1: stay in HOLD; all registers hold.
- stallF = stallD | (state==HOLD).
  - Fetch-0 must not issue a new request while an older fetch is unconsumed.
  - stallF is not asserted by flush.
- Latency:
  - A request issued in cycle t is visible on the D outputs in cycle t+2 when no stall occurs.
  - Sustained throughput is one instruction per cycle.
- Ordering: instructions reach decode in request order, each exactly once. The hold buffer depth is 1, which is sufficient because stallF blocks further requests.
- Data rules:
  - imemRdata is ignored in any cycle not preceded by a captured request.
  - Predecode is combinational from the registered instrD and is forced to 0 when validD=0.

Test Plan:
- Reset, then requests for pc 0x0, 0x4, 0x8 in consecutive cycles with rdata 0x00500093, 0x00a00113, 0x002081b3 -> validD=1 in cycles 2, 3, 4 with matching pcD/instrD/pcPlus4D; stallF=0 throughout.
- Request pc 0x10 (rdata 0x0000006f), then stallD=1 for 3 cycles starting the data-return cycle -> HOLD; stallF=1; D outputs unchanged. After release: pcD=0x10, instrD=0x0000006f, isJalD=1, exactly once, with no duplicate.
- Request pc 0x20 with bPredictedTakenF0=1, and flush=1 in the data-return cycle -> next edge validD=0, instrD=0x00000013; the request issued during the flush cycle yields no output; the next post-flush request is delivered normally.
- Flush while in HOLD with stallD=1 -> IDLE; validD=0; stallF drops to stallD only; the held instruction is never presented.
- Assert rst=0 asynchronously mid-cycle while in PEND -> outputs take reset values immediately, without waiting for a clock edge; rdata returning the next cycle is ignored and validD stays 0.
- Branch predecode: deliver 0x00208463 at pc 0x40 -> isBranchD=1, pcPlus4D=0x44; deliver 0x000080e7 -> isJalrD=1; a bubble cycle gives all flags 0.
